// File: rtl/bsg_ral_link_test_sequencer.sv
// bsg_ral_link_test_sequencer
//
// Sequences a link test across a set of master-mode test nodes: pulses the
// node reset, enables traffic until every tested node has sent its burst,
// waits for the receive counts to catch up (or a drain timeout), then scores
// each node and reports the result until the next start or reset.
//
// Build option: define BSG_RAL_LINK_TEST_SEQ_SERIAL_EN to test the nodes one
// at a time (node 0 first); by default all nodes are tested concurrently.
//
// Ports
//   clk_i         clock, all logic on the rising edge
//   reset_n_i     synchronous active-low reset
//   start_i       start a run (accepted only in IDLE or DONE)
//   burst_len_i   packets per node, latched when start is accepted
//   error_i       per-node sticky error flags from the nodes
//   sent_i        per-node sent counts, node k at [32k+31:32k]
//   received_i    per-node received counts, same packing
//   node_reset_o  active-high reset to the nodes
//   en_o          per-node traffic enable
//   busy_o        run in progress
//   done_o        result valid
//   pass_o        every tested node passed (valid with done_o)
//   fail_mask_o   bit k set when node k failed (valid with done_o)

module bsg_ral_link_test_sequencer #(
    parameter int num_nodes_p     = 4,
    parameter int reset_cycles_p  = 4,
    parameter int drain_timeout_p = 1024
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        start_i,
    input  logic [31:0]                 burst_len_i,
    input  logic [num_nodes_p-1:0]      error_i,
    input  logic [32*num_nodes_p-1:0]   sent_i,
    input  logic [32*num_nodes_p-1:0]   received_i,
    output logic                        node_reset_o,
    output logic [num_nodes_p-1:0]      en_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        pass_o,
    output logic [num_nodes_p-1:0]      fail_mask_o
);

    localparam int RCW = (reset_cycles_p  > 1) ? $clog2(reset_cycles_p)  : 1;
    localparam int DCW = (drain_timeout_p > 1) ? $clog2(drain_timeout_p) : 1;

    localparam logic [RCW-1:0] RST_LAST   = RCW'(reset_cycles_p - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(drain_timeout_p - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_SEND  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            burst_len_q, burst_len_d;
    logic [RCW-1:0]         rst_cnt_q, rst_cnt_d;
    logic [DCW-1:0]         drain_cnt_q, drain_cnt_d;
    logic [num_nodes_p-1:0] fail_mask_q, fail_mask_d;
    logic [num_nodes_p-1:0] err_seen_q, err_seen_d;
    logic [num_nodes_p-1:0] active;

    logic [num_nodes_p-1:0] below_burst;
    logic [num_nodes_p-1:0] eval_fail;
    logic                   all_sent;
    logic                   all_rcvd;
    logic                   drain_exit;

`ifdef BSG_RAL_LINK_TEST_SEQ_SERIAL_EN
    localparam int IW = (num_nodes_p > 1) ? $clog2(num_nodes_p) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(num_nodes_p - 1);

    logic [IW-1:0] node_idx_q, node_idx_d;

    always_comb begin
        active             = '0;
        active[node_idx_q] = 1'b1;
    end
`else
    assign active = '1;
`endif

    // Per-node count comparisons; inactive nodes never block a transition.
    always_comb begin
        below_burst = '0;
        eval_fail   = '0;
        all_sent    = 1'b1;
        all_rcvd    = 1'b1;
        for (int k = 0; k < num_nodes_p; k++) begin
            below_burst[k] = sent_i[32*k +: 32] < burst_len_q;
            if (active[k] && (sent_i[32*k +: 32] != burst_len_q)) begin
                all_sent = 1'b0;
            end
            if (active[k] && (received_i[32*k +: 32] != sent_i[32*k +: 32])) begin
                all_rcvd = 1'b0;
            end
            // error_i is still being sampled in the evaluate cycle itself
            eval_fail[k] = active[k] &
                           (err_seen_q[k] | error_i[k] |
                            (received_i[32*k +: 32] != sent_i[32*k +: 32]));
        end
    end

    assign drain_exit = all_rcvd || (drain_cnt_q == DRAIN_LAST);

    always_comb begin
        state_d     = state_q;
        burst_len_d = burst_len_q;
        rst_cnt_d   = rst_cnt_q;
        drain_cnt_d = drain_cnt_q;
        fail_mask_d = fail_mask_q;
        err_seen_d  = err_seen_q;
`ifdef BSG_RAL_LINK_TEST_SEQ_SERIAL_EN
        node_idx_d  = node_idx_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d     = ST_RESET;
                    burst_len_d = burst_len_i;
                    rst_cnt_d   = '0;
                    fail_mask_d = '0;
                    err_seen_d  = '0;
`ifdef BSG_RAL_LINK_TEST_SEQ_SERIAL_EN
                    node_idx_d  = '0;
`endif
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_SEND;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                err_seen_d = err_seen_q | error_i;
                if (all_sent) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                err_seen_d  = err_seen_q | error_i;
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_exit) begin
                    fail_mask_d = fail_mask_q | eval_fail;
`ifdef BSG_RAL_LINK_TEST_SEQ_SERIAL_EN
                    if (node_idx_q != IDX_LAST) begin
                        node_idx_d = node_idx_q + 1'b1;
                        state_d    = ST_SEND;
                    end else begin
                        state_d = ST_DONE;
                    end
`else
                    state_d = ST_DONE;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            rst_cnt_q   <= '0;
            drain_cnt_q <= '0;
            fail_mask_q <= '0;
            err_seen_q  <= '0;
`ifdef BSG_RAL_LINK_TEST_SEQ_SERIAL_EN
            node_idx_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            fail_mask_q <= fail_mask_d;
            err_seen_q  <= err_seen_d;
`ifdef BSG_RAL_LINK_TEST_SEQ_SERIAL_EN
            node_idx_q  <= node_idx_d;
`endif
        end
    end

    // The burst length only matters once a start has loaded it.
    always_ff @(posedge clk_i) begin
        burst_len_q <= burst_len_d;
    end

    // Enable drops in the same cycle sent_i reaches the burst, so no node
    // ever issues an extra packet.
    assign en_o         = (state_q == ST_SEND) ? (active & below_burst) : '0;
    assign node_reset_o = (state_q == ST_RESET);
    assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o       = (state_q == ST_DONE);
    assign pass_o       = done_o && (fail_mask_q == '0);
    assign fail_mask_o  = done_o ? fail_mask_q : '0;

endmodule
